// File: rtl/iterdiv_if.sv
// Operand/result handshake bundle for iterative_divider.
// op encoding: 0 UDIV, 1 SDIV, 2 UMOD, 3 SMOD; op[2] set means non-division.
interface iterdiv_if #(
  parameter int unsigned Width = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] result;
  logic             div_by_zero;
  logic             carry;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div_by_zero, carry
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div_by_zero, carry
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divide/modulo unit, BitsPerCycle quotient bits per clock.
// Define ITERDIV_EARLY_OUT_EN to skip iteration when |a| < |b|.
module iterative_divider #(
  parameter int unsigned Width        = 64,
  parameter int unsigned BitsPerCycle = 1
) (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       flush_i,
  iterdiv_if.slave  bus
);

  localparam int unsigned NumIter = Width / BitsPerCycle;
  localparam int unsigned CntW    = $clog2(NumIter);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [Width-1:0] a_q, b_q;
  logic [Width-1:0] quo_q, rem_q, dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             qneg_q, rneg_q, zero_q;
  logic [Width-1:0] result_q;
  logic             carry_q, dbz_q;

  logic             is_div, is_signed, is_mod;
  logic             a_neg, b_neg, b_zero;
  logic [Width-1:0] mag_a, mag_b;
  logic [Width-1:0] quo_nxt, rem_nxt;
  logic [Width:0]   trial;
  logic [Width-1:0] q_signed, r_signed, fix_res;
  logic             fix_carry, fix_dbz;

  assign is_div    = ~op_q[2];
  assign is_signed = op_q[0];
  assign is_mod    = op_q[1];
  assign a_neg     = is_signed & a_q[Width-1];
  assign b_neg     = is_signed & b_q[Width-1];
  assign mag_a     = a_neg ? -a_q : a_q;
  assign mag_b     = b_neg ? -b_q : b_q;
  assign b_zero    = (b_q == '0);

  // Restoring shift-subtract; rem stays below the divisor, so W+1 bits suffice.
  always_comb begin
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    trial   = '0;
    for (int unsigned i = 0; i < BitsPerCycle; i++) begin
      trial   = {rem_nxt, quo_nxt[Width-1]};
      quo_nxt = {quo_nxt[Width-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial      = trial - {1'b0, dvs_q};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = trial[Width-1:0];
    end
  end

  always_comb begin
    q_signed = qneg_q ? -quo_q : quo_q;
    r_signed = rneg_q ? -rem_q : rem_q;
    if (!is_div) begin
      fix_res = '0;
    end else if (zero_q) begin
      fix_res = is_mod ? a_q : '1;
    end else begin
      fix_res = is_mod ? r_signed : q_signed;
    end
    fix_carry = is_div & is_signed & fix_res[Width-1];
    fix_dbz   = is_div & zero_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.in_valid) state_d = StPrep;
      StPrep: begin
        if (!is_div || b_zero) begin
          state_d = StFix;
`ifdef ITERDIV_EARLY_OUT_EN
        end else if (mag_a < mag_b) begin
          state_d = StFix;
`endif
        end else begin
          state_d = StIter;
        end
      end
      StIter: if (cnt_q == CntW'(NumIter - 1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_comb begin
    bus.in_ready    = (state_q == StIdle);
    bus.out_valid   = (state_q == StDone);
    bus.result      = result_q;
    bus.div_by_zero = dbz_q;
    bus.carry       = carry_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (!flush_i) begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
        end
        StPrep: begin
          quo_q  <= mag_a;
          dvs_q  <= mag_b;
          rem_q  <= '0;
          cnt_q  <= '0;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          zero_q <= b_zero;
`ifdef ITERDIV_EARLY_OUT_EN
          if (mag_a < mag_b) begin
            quo_q <= '0;
            rem_q <= mag_a;
          end
`endif
        end
        StIter: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CntW'(1);
        end
        StFix: begin
          result_q <= fix_res;
          carry_q  <= fix_carry;
          dbz_q    <= fix_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule
